serial_adder_ctrl: RTL and testbench

//  Controller that time-shares one external Full_Adder cell to add two WIDTH-bit operands bit-serially.

---
 rtl/serial_adder_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller that time-shares one external Full_Adder cell.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Carry_in,
  output logic             FA_A,
  output logic             FA_B,
  output logic             FA_Cin,
  input  logic             FA_Sum,
  input  logic             FA_Cout,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum_out,
  output logic             Carry_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [WIDTH-1:0] sum_out_q, sum_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic             run;

  assign run = (state_q == S_RUN);

  // The cell is only driven while a bit is actually being processed.
  assign FA_A      = run & a_q[0];
  assign FA_B      = run & b_q[0];
  assign FA_Cin    = run & carry_q;
  assign Busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign Done      = done_q;
  assign Sum_out   = sum_out_q;
  assign Carry_out = cout_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    sum_out_d = sum_out_q;
    cout_d    = cout_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          a_d     = A_in;
          b_d     = B_in;
          carry_d = Carry_in;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = {FA_Sum, sum_q[WIDTH-1:1]};
        carry_d = FA_Cout;
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) state_d = S_DONE;
      end
      S_DONE: begin
        sum_out_d = sum_q;
        cout_d    = carry_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      sum_out_q <= '0;
      cout_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      sum_out_q <= sum_out_d;
      cout_q    <= cout_d;
      done_q    <= done_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // Carry into the MSB is the carry flop value while the last bit is on the cell.
  logic cmsb_q, cmsb_d, ovf_q, ovf_d;

  always_comb begin
    cmsb_d = cmsb_q;
    ovf_d  = ovf_q;
    if (run && (cnt_q == LAST_BIT)) cmsb_d = carry_q;
    if (state_q == S_DONE) ovf_d = cmsb_q ^ carry_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cmsb_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cmsb_q <= cmsb_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl with a behavioural Full_Adder cell.
// Overflow checks are included when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic [WIDTH-1:0] A_in = '0;
  logic [WIDTH-1:0] B_in = '0;
  logic             Carry_in = 1'b0;
  logic             FA_A, FA_B, FA_Cin, FA_Sum, FA_Cout;
  logic             Busy, Done, Carry_out;
  logic [WIDTH-1:0] Sum_out;
`ifdef SERIAL_ADD_OVF_EN
  logic             Overflow;
`endif

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A_in(A_in), .B_in(B_in), .Carry_in(Carry_in),
    .FA_A(FA_A), .FA_B(FA_B), .FA_Cin(FA_Cin), .FA_Sum(FA_Sum), .FA_Cout(FA_Cout),
    .Busy(Busy), .Done(Done), .Sum_out(Sum_out), .Carry_out(Carry_out)
`ifdef SERIAL_ADD_OVF_EN
    , .Overflow(Overflow)
`endif
  );

  assign FA_Sum  = FA_A ^ FA_B ^ FA_Cin;
  assign FA_Cout = (FA_A & FA_B) | (FA_A & FA_Cin) | (FA_B & FA_Cin);

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  exp_t             exp_q[$];
  int               n_checks = 0;
  int               n_fail = 0;
  int               cyc = 0;
  logic [WIDTH-1:0] last_sum = '0;
  logic             last_cout = 1'b0;
  logic             last_ovf = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per Done pulse and checks hold behaviour otherwise.
  always @(negedge Clk) begin
    if (Reset) begin
      exp_q.delete();
      last_sum  = '0;
      last_cout = 1'b0;
      last_ovf  = 1'b0;
    end else begin
      if (!Busy) chk("fa_idle_zero", 32'({FA_A, FA_B, FA_Cin}), 32'(0));
      if (Done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(1), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sum_out", 32'(Sum_out), 32'(e.s));
          chk("carry_out", 32'(Carry_out), 32'(e.c));
`ifdef SERIAL_ADD_OVF_EN
          chk("overflow", 32'(Overflow), 32'(e.o));
          last_ovf = e.o;
`endif
          last_sum  = e.s;
          last_cout = e.c;
        end
      end else begin
        chk("result_hold", 32'({Sum_out, Carry_out}), 32'({last_sum, last_cout}));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf_hold", 32'(Overflow), 32'(last_ovf));
`endif
      end
    end
  end

  task automatic wait_done(output int at, output bit got);
    got = 1'b0;
    at  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) begin
        got = 1'b1;
        at  = cyc;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'(1));
  endtask

  task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] es, input logic ec, input logic eo);
    int n, busy;
    bit got;
    @(posedge Clk); #1;
    exp_q.push_back('{s: es, c: ec, o: eo});
    A_in = a; B_in = b; Carry_in = cin; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    n = 0; busy = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      n++;
      if (Busy) busy++;
      if (Done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'(1));
    chk("done_latency", 32'(n), 32'(WIDTH + 2));
    chk("busy_cycles", 32'(busy), 32'(WIDTH + 1));
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (Done) n++;
    end
  endtask

  initial begin
    #200000;
    $display("timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, t1, t2, t3, t4;
    bit got;

    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_busy", 32'(Busy), 32'(0));
    chk("rst_done", 32'(Done), 32'(0));
    chk("rst_sum", 32'(Sum_out), 32'(0));
    chk("rst_cout", 32'(Carry_out), 32'(0));
    chk("rst_fa", 32'({FA_A, FA_B, FA_Cin}), 32'(0));

    // Directed vectors: a, b, cin -> sum, cout, signed overflow
    run_add(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_add(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
    run_add(8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b0);
    run_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // Start during RUN is ignored
    @(posedge Clk); #1;
    exp_q.push_back('{s: 8'h10, c: 1'b0, o: 1'b0});
    A_in = 8'h0F; B_in = 8'h01; Carry_in = 1'b0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (2) begin @(posedge Clk); #1; end
    A_in = 8'hEE; B_in = 8'h11; Carry_in = 1'b1; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done(t1, got);
    count_dones(15, n);
    chk("ignored_start_no_done", 32'(n), 32'(0));

    // Reset mid-operation aborts without a Done pulse
    @(posedge Clk); #1;
    exp_q.push_back('{s: 8'h33, c: 1'b0, o: 1'b0});
    A_in = 8'h11; B_in = 8'h22; Carry_in = 1'b0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_busy", 32'(Busy), 32'(0));
    chk("abort_sum", 32'(Sum_out), 32'(0));
    chk("abort_cout", 32'(Carry_out), 32'(0));
    chk("abort_done", 32'(Done), 32'(0));
    count_dones(14, n);
    chk("abort_no_done", 32'(n), 32'(0));
    run_add(8'h35, 8'h4A, 1'b1, 8'h80, 1'b0, 1'b1);

    // Start held high: one result every WIDTH+2 cycles
    @(posedge Clk); #1;
    repeat (4) exp_q.push_back('{s: 8'h47, c: 1'b0, o: 1'b0});
    A_in = 8'h12; B_in = 8'h34; Carry_in = 1'b1; Start = 1'b1;
    wait_done(t1, got);
    wait_done(t2, got);
    wait_done(t3, got);
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done(t4, got);
    chk("held_period_1", 32'(t2 - t1), 32'(WIDTH + 2));
    chk("held_period_2", 32'(t3 - t2), 32'(WIDTH + 2));
    chk("held_period_3", 32'(t4 - t3), 32'(WIDTH + 2));
    count_dones(15, n);
    chk("held_no_extra_done", 32'(n), 32'(0));

    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
